// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_sequencer_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam int DEF_MUL_TIMEOUT = 40;
  localparam int DEF_DIV_TIMEOUT = 40;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_RUN    = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Watchdog increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response interface between the CPU control unit and the mult/div sequencer.
interface muldiv_sequencer_if;
  import muldiv_sequencer_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic              op_code;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic              timeout_err;

  modport master (
    output op_valid, op_code, opnd_a, opnd_b,
    input  op_ready, hi, lo, busy, done, div_zero, timeout_err
  );

  modport slave (
    input  op_valid, op_code, opnd_a, opnd_b,
    output op_ready, hi, lo, busy, done, div_zero, timeout_err
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences the shared iterative multiplier/divider: clear, run with watchdog,
// commit result into architectural HI/LO. All outputs are registered.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MUL_TIMEOUT = DEF_MUL_TIMEOUT,
  parameter int DIV_TIMEOUT = DEF_DIV_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  muldiv_sequencer_if.slave req,
  output logic              mult_reset,
  output logic              mult_ctrl,
  output logic              div_reset,
  output logic              div_ctrl,
  output logic [DATA_W-1:0] unit_a,
  output logic [DATA_W-1:0] unit_b,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  input  logic              mult_done,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  input  logic              div_done
);

  // Watchdog fires on the last allowed RUN cycle (counter starts at 0).
  localparam logic [CNT_W-1:0] MUL_LIM = CNT_W'(MUL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DIV_LIM = CNT_W'(DIV_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] unit_a_q, unit_a_d;
  logic [DATA_W-1:0] unit_b_q, unit_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              op_ready_q, op_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_zero_q, div_zero_d;
  logic              timeout_err_q, timeout_err_d;
  logic              mult_reset_q, mult_reset_d;
  logic              mult_ctrl_q, mult_ctrl_d;
  logic              div_reset_q, div_reset_d;
  logic              div_ctrl_q, div_ctrl_d;

  logic              sel_done;
  logic [DATA_W-1:0] sel_hi;
  logic [DATA_W-1:0] sel_lo;
  logic [CNT_W-1:0]  sel_lim;

  // Route the selected unit's status/result; the other unit is ignored.
  always_comb begin
    sel_done = (op_q == OP_DIV) ? div_done : mult_done;
    sel_hi   = (op_q == OP_DIV) ? div_hi   : mult_hi;
    sel_lo   = (op_q == OP_DIV) ? div_lo   : mult_lo;
    sel_lim  = (op_q == OP_DIV) ? DIV_LIM  : MUL_LIM;
  end

  // Next-state, datapath capture and registered output decode.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    unit_a_d      = unit_a_q;
    unit_b_d      = unit_b_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    done_d        = 1'b0;
    div_zero_d    = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req.op_valid) begin
          op_d          = req.op_code;
          unit_a_d      = req.opnd_a;
          unit_b_d      = req.opnd_b;
          timeout_err_d = 1'b0;
          if (req.op_code == OP_DIV && req.opnd_b == '0) begin
            div_zero_d = 1'b1;
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // cnt_q == 0 marks the first RUN cycle, where a done left over
        // from the previous operation must not be trusted.
        if (sel_done && cnt_q != '0) begin
          state_d = ST_COMMIT;
        end else if (cnt_q >= sel_lim) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_COMMIT: begin
        hi_d    = sel_hi;
        lo_d    = sel_lo;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Unit controls are decoded from the next state so they line up with state_q.
    op_ready_d   = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    mult_reset_d = (state_d == ST_CLEAR) && (op_d == OP_MULT);
    div_reset_d  = (state_d == ST_CLEAR) && (op_d == OP_DIV);
    mult_ctrl_d  = (state_d == ST_RUN)   && (op_d == OP_MULT);
    div_ctrl_d   = (state_d == ST_RUN)   && (op_d == OP_DIV);
  end

  // State, datapath and output registers; reset clears everything including HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_MULT;
      unit_a_q      <= '0;
      unit_b_q      <= '0;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      op_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_zero_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      mult_reset_q  <= 1'b0;
      mult_ctrl_q   <= 1'b0;
      div_reset_q   <= 1'b0;
      div_ctrl_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      unit_a_q      <= unit_a_d;
      unit_b_q      <= unit_b_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      op_ready_q    <= op_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_zero_q    <= div_zero_d;
      timeout_err_q <= timeout_err_d;
      mult_reset_q  <= mult_reset_d;
      mult_ctrl_q   <= mult_ctrl_d;
      div_reset_q   <= div_reset_d;
      div_ctrl_q    <= div_ctrl_d;
    end
  end

  assign req.op_ready    = op_ready_q;
  assign req.busy        = busy_q;
  assign req.done        = done_q;
  assign req.div_zero    = div_zero_q;
  assign req.timeout_err = timeout_err_q;
  assign req.hi          = hi_q;
  assign req.lo          = lo_q;
  assign mult_reset      = mult_reset_q;
  assign mult_ctrl       = mult_ctrl_q;
  assign div_reset       = div_reset_q;
  assign div_ctrl        = div_ctrl_q;
  assign unit_a          = unit_a_q;
  assign unit_b          = unit_b_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with simple behavioural mult/div unit models.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mult_reset, mult_ctrl, div_reset, div_ctrl;
  logic [31:0] unit_a, unit_b;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        mult_done, div_done;

  muldiv_sequencer_if ifc();

  muldiv_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (ifc.slave),
    .mult_reset(mult_reset),
    .mult_ctrl (mult_ctrl),
    .div_reset (div_reset),
    .div_ctrl  (div_ctrl),
    .unit_a    (unit_a),
    .unit_b    (unit_b),
    .mult_hi   (mult_hi),
    .mult_lo   (mult_lo),
    .mult_done (mult_done),
    .div_hi    (div_hi),
    .div_lo    (div_lo),
    .div_done  (div_done)
  );

  always #5 clk = ~clk;

  // Unit models: count enabled cycles after a clear; done once latency reached.
  int   mcnt = 0;
  int   dcnt = 0;
  logic mstarted = 1'b0;
  logic dstarted = 1'b0;
  int   mul_lat = 33;
  int   div_lat = 20;
  logic div_force = 1'b0;
  logic [63:0] prod;

  always @(posedge clk) begin
    if (mult_reset) begin
      mcnt     <= 0;
      mstarted <= 1'b1;
    end else if (mult_ctrl) begin
      mcnt <= mcnt + 1;
    end
    if (div_reset) begin
      dcnt     <= 0;
      dstarted <= 1'b1;
    end else if (div_ctrl) begin
      dcnt <= dcnt + 1;
    end
  end

  assign prod      = {32'b0, unit_a} * {32'b0, unit_b};
  assign mult_hi   = prod[63:32];
  assign mult_lo   = prod[31:0];
  assign mult_done = mstarted && (mcnt >= mul_lat - 1);
  assign div_lo    = (unit_b == 32'd0) ? 32'd0 : unit_a / unit_b;
  assign div_hi    = (unit_b == 32'd0) ? 32'd0 : unit_a % unit_b;
  assign div_done  = (dstarted && (dcnt >= div_lat - 1)) || (div_force && dcnt == 0);

  int n_cmp = 0;
  int n_err = 0;

  // Observations collected by run_op, cycle 1 = first cycle after the accept edge.
  int obs_end, obs_busy, obs_done_cyc, obs_done_cnt, obs_dz_cyc, obs_dz_cnt;
  int obs_mres_first, obs_mres_cnt, obs_mctl_first, obs_mctl_cnt;
  int obs_dres_cnt, obs_dctl_cnt, obs_both, obs_opnd_changed;

  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input int budget, input bit hold);
    obs_end = -1; obs_busy = 0; obs_done_cyc = -1; obs_done_cnt = 0;
    obs_dz_cyc = -1; obs_dz_cnt = 0; obs_mres_first = -1; obs_mres_cnt = 0;
    obs_mctl_first = -1; obs_mctl_cnt = 0; obs_dres_cnt = 0; obs_dctl_cnt = 0;
    obs_both = 0; obs_opnd_changed = 0;
    @(negedge clk);
    ifc.op_valid = 1'b1; ifc.op_code = op; ifc.opnd_a = a; ifc.opnd_b = b;
    @(posedge clk);
    #1;
    if (hold) begin
      ifc.op_code = OP_DIV; ifc.opnd_a = 32'd50; ifc.opnd_b = 32'd5;
    end else begin
      ifc.op_valid = 1'b0;
    end
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (ifc.busy) obs_busy++;
      if (ifc.done) begin obs_done_cnt++; if (obs_done_cyc < 0) obs_done_cyc = n; end
      if (ifc.div_zero) begin obs_dz_cnt++; if (obs_dz_cyc < 0) obs_dz_cyc = n; end
      if (mult_reset) begin obs_mres_cnt++; if (obs_mres_first < 0) obs_mres_first = n; end
      if (mult_ctrl) begin obs_mctl_cnt++; if (obs_mctl_first < 0) obs_mctl_first = n; end
      if (div_reset) obs_dres_cnt++;
      if (div_ctrl) obs_dctl_cnt++;
      if (mult_ctrl && div_ctrl) obs_both++;
      if (hold && ifc.busy && unit_a !== a) obs_opnd_changed++;
      if (ifc.op_ready) begin obs_end = n; break; end
    end
    ifc.op_valid = 1'b0;
    n_cmp++;
    if (obs_end < 0) begin
      n_err++;
      $display("FAIL run_op_bound: no return to op_ready within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    logic [8:0] flags;
    ifc.op_valid = 1'b0; ifc.op_code = OP_MULT; ifc.opnd_a = '0; ifc.opnd_b = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    flags = {ifc.op_ready, ifc.busy, ifc.done, ifc.div_zero, ifc.timeout_err,
             mult_reset, mult_ctrl, div_reset, div_ctrl};
    n_cmp++;
    if (flags !== 9'd0) begin n_err++; $display("FAIL reset_flags: got %b expected %b", flags, 9'd0); end
    n_cmp++;
    if ({ifc.hi, ifc.lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo: got %h expected 0", {ifc.hi, ifc.lo}); end
    n_cmp++;
    if ({unit_a, unit_b} !== 64'd0) begin n_err++; $display("FAIL reset_units: got %h expected 0", {unit_a, unit_b}); end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ifc.op_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ifc.op_ready); end
  endtask

  task automatic test_mult_basic();
    mul_lat = 33;
    run_op(OP_MULT, 32'd7, 32'd6, 60, 1'b0);
    n_cmp++;
    if (obs_done_cyc !== 36) begin n_err++; $display("FAIL mult_done_cycle: got %0d expected 36", obs_done_cyc); end
    n_cmp++;
    if (obs_busy !== 35) begin n_err++; $display("FAIL mult_busy_cycles: got %0d expected 35", obs_busy); end
    n_cmp++;
    if (ifc.hi !== 32'd0 || ifc.lo !== 32'd42) begin n_err++; $display("FAIL mult_7x6: got %h_%h expected 0_2a", ifc.hi, ifc.lo); end
    n_cmp++;
    if (obs_mctl_cnt !== 33 || obs_dctl_cnt !== 0) begin n_err++; $display("FAIL mult_ctrl_cycles: got %0d/%0d expected 33/0", obs_mctl_cnt, obs_dctl_cnt); end
    @(negedge clk);
    n_cmp++;
    if (ifc.done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse: got %b expected 0", ifc.done); end
  endtask

  task automatic test_mult_boundary();
    mul_lat = 33;
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 60, 1'b0);
    n_cmp++;
    if (ifc.hi !== 32'd1 || ifc.lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mult_ffff_x2: got %h_%h expected 1_fffffffe", ifc.hi, ifc.lo); end
    n_cmp++;
    if (obs_mres_cnt !== 1 || obs_mres_first !== 1) begin n_err++; $display("FAIL mult_reset_pulse: got cnt %0d first %0d expected 1/1", obs_mres_cnt, obs_mres_first); end
    n_cmp++;
    if (obs_mctl_first !== 2) begin n_err++; $display("FAIL mult_ctrl_rise: got %0d expected 2", obs_mctl_first); end
    n_cmp++;
    if (obs_dres_cnt !== 0) begin n_err++; $display("FAIL mult_no_div_reset: got %0d expected 0", obs_dres_cnt); end
  endtask

  task automatic test_div_zero();
    run_op(OP_DIV, 32'd100, 32'd0, 20, 1'b0);
    n_cmp++;
    if (obs_dz_cyc !== 1 || obs_dz_cnt !== 1) begin n_err++; $display("FAIL divz_pulse: got cyc %0d cnt %0d expected 1/1", obs_dz_cyc, obs_dz_cnt); end
    n_cmp++;
    if (obs_dres_cnt !== 0 || obs_dctl_cnt !== 0 || obs_busy !== 0) begin n_err++; $display("FAIL divz_no_start: got rst %0d ctl %0d busy %0d expected 0/0/0", obs_dres_cnt, obs_dctl_cnt, obs_busy); end
    n_cmp++;
    if (ifc.hi !== 32'd1 || ifc.lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL divz_hilo_kept: got %h_%h expected 1_fffffffe", ifc.hi, ifc.lo); end
    @(negedge clk);
    n_cmp++;
    if (ifc.div_zero !== 1'b0 || ifc.done !== 1'b0) begin n_err++; $display("FAIL divz_one_cycle: got dz %b done %b expected 0/0", ifc.div_zero, ifc.done); end
  endtask

  task automatic test_div_stale();
    div_lat = 20;
    div_force = 1'b1;
    run_op(OP_DIV, 32'd100, 32'd7, 60, 1'b0);
    div_force = 1'b0;
    n_cmp++;
    if (obs_done_cyc !== 23) begin n_err++; $display("FAIL div_stale_latency: got %0d expected 23", obs_done_cyc); end
    n_cmp++;
    if (obs_dctl_cnt !== 20 || obs_mctl_cnt !== 0) begin n_err++; $display("FAIL div_ctrl_cycles: got %0d/%0d expected 20/0", obs_dctl_cnt, obs_mctl_cnt); end
    n_cmp++;
    if (ifc.hi !== 32'd2 || ifc.lo !== 32'd14) begin n_err++; $display("FAIL div_100_7: got %h_%h expected 2_e", ifc.hi, ifc.lo); end
  endtask

  task automatic test_timeout();
    mul_lat = 100;
    run_op(OP_MULT, 32'd5, 32'd5, 80, 1'b0);
    n_cmp++;
    if (ifc.timeout_err !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b expected 1", ifc.timeout_err); end
    n_cmp++;
    if (obs_mctl_cnt !== 40 || obs_end !== 42) begin n_err++; $display("FAIL to_run_cycles: got ctl %0d end %0d expected 40/42", obs_mctl_cnt, obs_end); end
    n_cmp++;
    if (obs_done_cnt !== 0 || ifc.hi !== 32'd2 || ifc.lo !== 32'd14) begin n_err++; $display("FAIL to_no_commit: got done %0d hilo %h_%h expected 0 2_e", obs_done_cnt, ifc.hi, ifc.lo); end
    n_cmp++;
    if (obs_both !== 0) begin n_err++; $display("FAIL to_one_ctrl: got %0d expected 0", obs_both); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ifc.timeout_err !== 1'b1 || ifc.op_ready !== 1'b1) begin n_err++; $display("FAIL to_sticky: got err %b ready %b expected 1/1", ifc.timeout_err, ifc.op_ready); end
  endtask

  task automatic test_async_reset();
    logic [8:0] flags;
    mul_lat = 33;
    @(negedge clk);
    ifc.op_valid = 1'b1; ifc.op_code = OP_MULT; ifc.opnd_a = 32'd3; ifc.opnd_b = 32'd4;
    @(posedge clk);
    #1 ifc.op_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ifc.timeout_err !== 1'b0) begin n_err++; $display("FAIL to_cleared_on_accept: got %b expected 0", ifc.timeout_err); end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (mult_ctrl !== 1'b1) begin n_err++; $display("FAIL arst_in_run: got %b expected 1", mult_ctrl); end
    #2 reset_n = 1'b0;
    #1;
    flags = {ifc.op_ready, ifc.busy, ifc.done, ifc.div_zero, ifc.timeout_err,
             mult_reset, mult_ctrl, div_reset, div_ctrl};
    n_cmp++;
    if (flags !== 9'd0) begin n_err++; $display("FAIL arst_flags: got %b expected %b", flags, 9'd0); end
    n_cmp++;
    if ({ifc.hi, ifc.lo, unit_a, unit_b} !== 128'd0) begin n_err++; $display("FAIL arst_data: got %h expected 0", {ifc.hi, ifc.lo, unit_a, unit_b}); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_op(OP_MULT, 32'd9, 32'd9, 60, 1'b0);
    n_cmp++;
    if (ifc.lo !== 32'd81 || ifc.hi !== 32'd0 || obs_done_cyc !== 36) begin n_err++; $display("FAIL arst_recover: got %h_%h at %0d expected 0_51 at 36", ifc.hi, ifc.lo, obs_done_cyc); end
  endtask

  task automatic test_back_to_back();
    mul_lat = 5;
    run_op(OP_MULT, 32'd2, 32'd3, 40, 1'b1);
    n_cmp++;
    if (ifc.hi !== 32'd0 || ifc.lo !== 32'd6 || obs_done_cyc !== 8) begin n_err++; $display("FAIL b2b_held_valid: got %h_%h at %0d expected 0_6 at 8", ifc.hi, ifc.lo, obs_done_cyc); end
    n_cmp++;
    if (obs_dctl_cnt !== 0 || obs_dres_cnt !== 0 || obs_opnd_changed !== 0) begin n_err++; $display("FAIL b2b_ignored: got ctl %0d rst %0d chg %0d expected 0/0/0", obs_dctl_cnt, obs_dres_cnt, obs_opnd_changed); end
    div_lat = 3;
    run_op(OP_DIV, 32'd100, 32'd7, 40, 1'b0);
    n_cmp++;
    if (ifc.hi !== 32'd2 || ifc.lo !== 32'd14 || obs_done_cyc !== 6) begin n_err++; $display("FAIL b2b_second: got %h_%h at %0d expected 2_e at 6", ifc.hi, ifc.lo, obs_done_cyc); end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_mult_boundary();
    test_div_zero();
    test_div_stale();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
